max_pool_2x2: RTL and testbench
===============================

# max_pool_2x2

Streaming 2x2, stride-2 max-pooling stage. It consumes the registered `PE_OUT_PACKET` stream leaving the ReLU stage, in raster order, one feature-map channel at a time. It emits one pooled `PE_OUT_PACKET` per 2x2 window toward the pooled-feature writeback path. A half-row line buffer holds the even-row pair maxima until the matching odd row arrives.

## Interface

Parameters:
- `DATA_WID`, default `` `CNN_XLEN ``: signed data width of `PE_OUT_PACKET.data`.
- `ROW_LEN`, default 32: input feature-map width in valid samples; even, ≥2.
- `FRAME_ROWS`, default 32: input feature-map height in rows; even, ≥2.

Ports:
- `clk`, input, 1: clock.
- `reset`, input, 1: synchronous, active-high.
- `pool_in_pk`, input, `PE_OUT_PACKET`: a sample is valid when `PE_state != INVALID`.
- `pool_out_pk`, output, `PE_OUT_PACKET`: pooled result; `PE_state = VALID` for exactly one cycle per window.
- `frame_done`, output, 1: one-cycle pulse coincident with the last pooled output of a frame.

## Operation

- Counters advance only on valid input samples; INVALID cycles are bubbles and change no state.
  - `col`: 0..`ROW_LEN`-1.
  - `row`: 0..`FRAME_ROWS`-1.
- FSM has two states:
  - ROW_EVEN is the reset state.
  - ROW_ODD is entered on the valid sample at `col = ROW_LEN-1` of an even row.
  - ROW_EVEN is re-entered on the valid sample at `col = ROW_LEN-1` of an odd row.
- Horizontal stage:
  - On a valid sample at even `col`, latch it into `hold`.
  - On a valid sample at odd `col`, compute `hmax = max(hold, sample)`.
- In ROW_EVEN, at odd `col`: write `hmax` into `linebuf[col>>1]`. Depth is `ROW_LEN/2` entries of `DATA_WID` bits.
- In ROW_ODD, at odd `col`:
  - Compute `vmax = max(hmax, linebuf[col>>1])`.
  - Register `vmax` to `pool_out_pk.data` with `PE_state = VALID`.
- All comparisons are signed, two's complement. Equal operands yield that value.
- Output behaviour on every cycle without a new result: `pool_out_pk.data = 0`, `PE_state = INVALID`.
- `frame_done` fires with the output produced by the sample at `row = FRAME_ROWS-1`, `col = ROW_LEN-1`.
- Wrap-around: after that sample, `col`, `row` and the FSM return to 0/0/ROW_EVEN. The next frame may start on the very next cycle.
- Reset while a window is partially accumulated:
  - Counters, FSM, `hold` and all outputs clear; the partial window is discarded with no output.
  - `linebuf` is not cleared. Every entry is rewritten by the next even row before it is read.

## Timing

- Reset values: `pool_out_pk.data = 0`, `pool_out_pk.PE_state = INVALID`, `frame_done = 0`, `col = 0`, `row = 0`, FSM = ROW_EVEN.
- Latency is 1 cycle: the output appears the cycle after the valid odd-row, odd-col sample that completes the window.
- Throughput is one input sample per cycle, sustained, with no backpressure.
- Output rate is at most one pooled value per 4 valid inputs, averaged over a row pair.
- The line-buffer write in ROW_EVEN and read in ROW_ODD never target the same entry in the same cycle. Read-during-write ordering is don't-care.
- Bubbles between any two samples, including inside a window, do not change results or latency relative to the completing sample.

## Configuration

- Macro: `POOL_AVG_EN`.
- Defined:
  - The block performs 2x2 average pooling.
  - `hold` keeps the sample; the horizontal stage computes a `DATA_WID+1`-bit signed pair sum.
  - `linebuf` entries widen to `DATA_WID+1` bits.
  - The odd row forms a `DATA_WID+2`-bit sum of 4 and outputs `sum >>> 2`: arithmetic shift, truncating toward −∞, low `DATA_WID` bits.
  - Latency, handshake and `frame_done` are unchanged.
- Undefined: max pooling as described above.

## Test plan

- `ROW_LEN=4`, `FRAME_ROWS=2`; back-to-back rows [1,5,2,3] then [4,0,7,6] -> output 5 the cycle after sample 0, output 7 the cycle after sample 6; `frame_done=1` only with the 7.
- Same data with 1–3 INVALID cycles between every sample -> identical outputs, each 1 cycle after its completing sample; INVALID outputs carry data 0.
- Signed window: rows [-3,-1] and [-8,-2] (`ROW_LEN=2`) -> output -1. Equal window [9,9;9,9] -> output 9.
- Two frames back-to-back with no gap (second frame all values +10) -> second frame outputs 15 and 17; `frame_done` pulses twice; counters wrap cleanly.
- Reset asserted after 3 samples of the odd row -> next cycle output INVALID/0 and `frame_done=0`; a fresh frame [2,4;6,8] then produces 8 with no stale output.
- `POOL_AVG_EN`: window [1,5;4,0] -> 2; window [-3,-1;-8,-2] -> -4 (sum -14 >>> 2).

Source files
------------

// File: rtl/max_pool_2x2.sv
// ---------------------------------------------------------------------------
// max_pool_2x2 -- streaming 2x2, stride-2 pooling stage.
//
// Consumes the PE_OUT_PACKET stream from the ReLU stage in raster order, one
// channel at a time, and emits one pooled PE_OUT_PACKET per 2x2 window.
// Even-row pair results wait in a half-row line buffer until the matching
// odd row arrives.
//
// Build option:
//   POOL_AVG_EN  defined   -> 2x2 average pooling (sum of 4, >>> 2)
//                undefined -> 2x2 max pooling (default)
//
// Parameters:
//   DATA_WID    signed sample width used from PE_OUT_PACKET.data (<= CNN_XLEN)
//   ROW_LEN     input width in valid samples (even, >= 2)
//   FRAME_ROWS  input height in rows (even, >= 2)
//
// Ports:
//   clk          clock
//   reset        synchronous, active-high
//   pool_in_pk   input sample; valid when PE_state != INVALID
//   pool_out_pk  pooled result; VALID for one cycle per window, else INVALID/0
//   frame_done   one-cycle pulse with the last pooled output of a frame
// ---------------------------------------------------------------------------

`ifndef CNN_XLEN
`define CNN_XLEN 16
`endif

package pe_pkg;
    localparam int XLEN = `CNN_XLEN;

    typedef enum logic [1:0] {
        INVALID = 2'd0,
        VALID   = 2'd1
    } pe_state_t;

    typedef struct packed {
        pe_state_t         PE_state;
        logic [XLEN-1:0]   data;
    } PE_OUT_PACKET;
endpackage

// state    | meaning
// ---------+---------------------------------------------------------------
// ROW_EVEN | even row: pair results are written into the line buffer
// ROW_ODD  | odd row: pair results merge with the line buffer and are output
module max_pool_2x2
    import pe_pkg::*;
#(
    parameter int DATA_WID   = `CNN_XLEN,
    parameter int ROW_LEN    = 32,
    parameter int FRAME_ROWS = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  PE_OUT_PACKET pool_in_pk,
    output PE_OUT_PACKET pool_out_pk,
    output logic         frame_done
);

    localparam int COL_W    = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
    localparam int ROW_W    = (FRAME_ROWS > 1) ? $clog2(FRAME_ROWS) : 1;
    localparam int LB_DEPTH = ROW_LEN / 2;
    localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
`ifdef POOL_AVG_EN
    // pair sums need one extra bit of headroom
    localparam int LB_W     = DATA_WID + 1;
`else
    localparam int LB_W     = DATA_WID;
`endif

    typedef enum logic {
        ROW_EVEN = 1'b0,
        ROW_ODD  = 1'b1
    } row_state_t;

    row_state_t                  state_q;
    row_state_t                  state_d;

    logic [COL_W-1:0]            col_q;
    logic [ROW_W-1:0]            row_q;
    logic signed [DATA_WID-1:0]  hold_q;
    logic signed [LB_W-1:0]      linebuf [LB_DEPTH];

    logic                        in_valid;
    logic signed [DATA_WID-1:0]  sample;
    logic                        col_odd;
    logic                        col_last;
    logic                        row_last;
    logic [LB_AW-1:0]            lb_idx;
    logic signed [LB_W-1:0]      lb_rd;
    logic signed [LB_W-1:0]      h_res;
    logic signed [DATA_WID-1:0]  v_res;
    logic                        lb_we;
    logic                        out_fire;

    assign in_valid = (pool_in_pk.PE_state != INVALID);
    assign sample   = pool_in_pk.data[DATA_WID-1:0];
    assign col_odd  = col_q[0];
    assign col_last = (col_q == COL_W'(ROW_LEN - 1));
    assign row_last = (row_q == ROW_W'(FRAME_ROWS - 1));
    assign lb_idx   = LB_AW'(col_q >> 1);
    assign lb_rd    = linebuf[lb_idx];

`ifdef POOL_AVG_EN
    logic signed [DATA_WID+1:0] v_sum;

    assign h_res = $signed({sample[DATA_WID-1], sample})
                 + $signed({hold_q[DATA_WID-1], hold_q});
    assign v_sum = $signed({h_res[LB_W-1], h_res})
                 + $signed({lb_rd[LB_W-1], lb_rd});
    // arithmetic shift floors toward -inf; the low bits are the average
    assign v_res = DATA_WID'(v_sum >>> 2);
`else
    assign h_res = (sample > hold_q) ? sample : hold_q;
    assign v_res = (h_res > lb_rd) ? h_res : lb_rd;
`endif

    always_comb begin
        state_d  = state_q;
        lb_we    = 1'b0;
        out_fire = 1'b0;
        if (in_valid) begin
            if (col_odd) begin
                if (state_q == ROW_EVEN) begin
                    lb_we = 1'b1;
                end else begin
                    out_fire = 1'b1;
                end
            end
            if (col_last) begin
                state_d = (state_q == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ROW_EVEN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q <= '0;
            row_q <= '0;
        end else if (in_valid) begin
            if (col_last) begin
                col_q <= '0;
                row_q <= row_last ? '0 : row_q + ROW_W'(1);
            end else begin
                col_q <= col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= '0;
        end else if (in_valid && !col_odd) begin
            hold_q <= sample;
        end
    end

    // No reset: every entry is rewritten by the next even row before the
    // odd row reads it.
    always_ff @(posedge clk) begin
        if (!reset && lb_we) begin
            linebuf[lb_idx] <= h_res;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pool_out_pk.PE_state <= INVALID;
            pool_out_pk.data     <= '0;
            frame_done           <= 1'b0;
        end else if (out_fire) begin
            pool_out_pk.PE_state <= VALID;
            pool_out_pk.data     <= XLEN'(v_res);
            frame_done           <= row_last && col_last;
        end else begin
            pool_out_pk.PE_state <= INVALID;
            pool_out_pk.data     <= '0;
            frame_done           <= 1'b0;
        end
    end

endmodule

// File: tb/tb_max_pool_2x2.sv
// ---------------------------------------------------------------------------
// tb_max_pool_2x2 -- directed bench for max_pool_2x2.
//
// Two instances: dut_a (ROW_LEN=4, FRAME_ROWS=2) and dut_b (ROW_LEN=2,
// FRAME_ROWS=2). Every cycle after a driven input is checked for output
// state, data and frame_done against hand-computed values. Expected values
// switch to the average-pooling results when POOL_AVG_EN is defined.
// ---------------------------------------------------------------------------
module tb_max_pool_2x2;
    import pe_pkg::*;

`ifdef POOL_AVG_EN
    localparam bit AVG = 1'b1;
`else
    localparam bit AVG = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    PE_OUT_PACKET in_a;
    PE_OUT_PACKET in_b;
    PE_OUT_PACKET out_a;
    PE_OUT_PACKET out_b;
    logic         done_a;
    logic         done_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    max_pool_2x2 #(.DATA_WID(XLEN), .ROW_LEN(4), .FRAME_ROWS(2)) dut_a (
        .clk         (clk),
        .reset       (reset),
        .pool_in_pk  (in_a),
        .pool_out_pk (out_a),
        .frame_done  (done_a)
    );

    max_pool_2x2 #(.DATA_WID(XLEN), .ROW_LEN(2), .FRAME_ROWS(2)) dut_b (
        .clk         (clk),
        .reset       (reset),
        .pool_in_pk  (in_b),
        .pool_out_pk (out_b),
        .frame_done  (done_b)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle on instance inst (0 = a, 1 = b), then check that
    // instance's output one cycle later.
    task automatic cyc(input int inst, input bit vld, input int val,
                       input bit ev, input int ed, input bit edn,
                       input string tag);
        PE_OUT_PACKET pk;
        PE_OUT_PACKET obs;
        logic         dn;
        pk.PE_state = vld ? VALID : INVALID;
        pk.data     = vld ? XLEN'(val) : '0;
        if (inst == 0) in_a = pk; else in_b = pk;
        @(posedge clk);
        #1;
        obs = (inst == 0) ? out_a : out_b;
        dn  = (inst == 0) ? done_a : done_b;
        check({tag, "_state"}, int'(obs.PE_state), ev ? int'(VALID) : int'(INVALID));
        check({tag, "_data"}, int'($signed(obs.data)), ev ? ed : 0);
        check({tag, "_done"}, int'(dn), int'(edn));
        in_a.PE_state = INVALID;
        in_a.data     = '0;
        in_b.PE_state = INVALID;
        in_b.data     = '0;
    endtask

    // One 4x2 frame on dut_a; e1/e2 are the two window results.
    task automatic run_a(input int v[8], input int e1, input int e2,
                         input bit gaps, input string tag);
        for (int i = 0; i < 8; i++) begin
            if (i == 5)      cyc(0, 1'b1, v[i], 1'b1, e1, 1'b0, tag);
            else if (i == 7) cyc(0, 1'b1, v[i], 1'b1, e2, 1'b1, tag);
            else             cyc(0, 1'b1, v[i], 1'b0, 0, 1'b0, tag);
            if (gaps) begin
                for (int g = 0; g < 1 + (i % 3); g++) begin
                    cyc(0, 1'b0, 0, 1'b0, 0, 1'b0, {tag, "_gap"});
                end
            end
        end
    endtask

    // One 2x2 frame on dut_b.
    task automatic run_b(input int v[4], input int e, input string tag);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) cyc(1, 1'b1, v[i], 1'b1, e, 1'b1, tag);
            else        cyc(1, 1'b1, v[i], 1'b0, 0, 1'b0, tag);
        end
    endtask

    initial begin
        reset         = 1'b1;
        in_a.PE_state = INVALID;
        in_a.data     = '0;
        in_b.PE_state = INVALID;
        in_b.data     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_state", int'(out_a.PE_state), int'(INVALID));
        check("rst_a_data", int'($signed(out_a.data)), 0);
        check("rst_a_done", int'(done_a), 0);
        check("rst_b_state", int'(out_b.PE_state), int'(INVALID));
        check("rst_b_data", int'($signed(out_b.data)), 0);
        check("rst_b_done", int'(done_b), 0);
        reset = 1'b0;

        // back-to-back frame: max 5 / 7, avg 10>>>2=2 / 18>>>2=4
        run_a('{1, 5, 2, 3, 4, 0, 7, 6}, AVG ? 2 : 5, AVG ? 4 : 7, 1'b0, "b2b");
        cyc(0, 1'b0, 0, 1'b0, 0, 1'b0, "b2b_idle");

        // same frame with 1..3 bubbles after every sample
        run_a('{1, 5, 2, 3, 4, 0, 7, 6}, AVG ? 2 : 5, AVG ? 4 : 7, 1'b1, "bub");

        // signed window: max -1, avg -14>>>2 = -4
        run_b('{-3, -1, -8, -2}, AVG ? -4 : -1, "sgn");
        // equal window
        run_b('{9, 9, 9, 9}, 9, "eq");

        // two frames with no gap; second frame +10: max 15/17, avg 12/14
        run_a('{1, 5, 2, 3, 4, 0, 7, 6}, AVG ? 2 : 5, AVG ? 4 : 7, 1'b0, "f1");
        run_a('{11, 15, 12, 13, 14, 10, 17, 16}, AVG ? 12 : 15, AVG ? 14 : 17,
              1'b0, "f2");

        // reset after 3 odd-row samples; a valid sample during reset is dropped
        cyc(0, 1'b1, 1, 1'b0, 0, 1'b0, "pr");
        cyc(0, 1'b1, 5, 1'b0, 0, 1'b0, "pr");
        cyc(0, 1'b1, 2, 1'b0, 0, 1'b0, "pr");
        cyc(0, 1'b1, 3, 1'b0, 0, 1'b0, "pr");
        cyc(0, 1'b1, 4, 1'b0, 0, 1'b0, "pr");
        cyc(0, 1'b1, 0, 1'b1, AVG ? 2 : 5, 1'b0, "pr");
        cyc(0, 1'b1, 7, 1'b0, 0, 1'b0, "pr");
        reset = 1'b1;
        cyc(0, 1'b1, 6, 1'b0, 0, 1'b0, "mid_rst");
        reset = 1'b0;
        // fresh frame: window [2,4;6,8] -> max 8 / avg 5; [1,1;1,1] -> 1
        run_a('{2, 4, 1, 1, 6, 8, 1, 1}, AVG ? 5 : 8, 1, 1'b0, "post");
        cyc(0, 1'b0, 0, 1'b0, 0, 1'b0, "post_idle");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
